div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the integer divide/remainder operations (DIV, DIVU, REM, REMU). It replaces the single-cycle combinational divide path: the execute stage hands it one operation through a valid/ready handshake. The block runs a radix-2 restoring division over 32 iterations, applies RV32M sign and special-case rules, and holds the 32-bit result until the consumer accepts it. It sits beside the ALU in the execute stage and is selected by the same 5-bit operator codes from define.sv.

## Interface
- No parameters; the data width is fixed at 32 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block can accept an operation; `(state==IDLE) && !rst`.
- operator  input  5  one of `ALU_OPERATOR_DIV/DIVU/REM/REMU`; sampled on accept.
- operand1  input  32  dividend; sampled on accept.
- operand2  input  32  divisor; sampled on accept.
- kill  input  1  pipeline flush; aborts any in-flight or held operation.
- out_valid  output  1  `result` is valid (registered).
- out_ready  input  1  the consumer takes `result`.
- result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU) (registered).
- busy  output  1  `state != IDLE`.

## Operation
- States: IDLE, CALC, DONE.
- Accept: `in_valid && in_ready && !kill` in IDLE.
  - Latch the op kind: signed flag, and quotient-vs-remainder select.
  - For signed ops, latch `|operand1|` and `|operand2|`, plus the sign flags `neg_q = s1^s2` and `neg_r = s1`. For unsigned ops, latch the operands as-is.
  - Clear the 33-bit partial remainder. Load the 5-bit iteration counter with 31.
- Fast path: checked on accept, with priority in this order. Load `result` directly and go IDLE→DONE.
  - operand2==0: quotient = 32'hFFFFFFFF; remainder = operand1 (unmodified).
  - Signed op with operand1==32'h80000000 and operand2==32'hFFFFFFFF: quotient = 32'h80000000; remainder = 0.
  - Operator not in the four div codes: result = 32'h0. This is a protocol error, but the handshake still completes.
- CALC, once per cycle:
  - `rem' = {rem[31:0], dvd[31]}`, and shift the dividend left by one.
  - If `rem' >= {1'b0, divisor}`: subtract the divisor and shift a 1 into the quotient LSB; otherwise shift in a 0.
  - Decrement the counter.
  - On the cycle the counter is 0: apply sign correction (negate the quotient if `neg_q`, negate the remainder if `neg_r`), register the selected value into `result`, and go CALC→DONE.
- DONE: `out_valid`=1. On `out_ready` go DONE→IDLE, with `out_valid`=0 the next cycle.
- kill, in any state: next state IDLE, `out_valid`=0, counter cleared. The pending result is discarded. kill has priority over accept, iteration and out_ready.
- Reset values: state IDLE, `out_valid`=0, `result`=32'h0, counter=0, internal registers=0. `in_ready`=0 and `busy`=0 while rst is high.

## Timing
- Normal latency: accept at cycle T; CALC occupies T+1..T+32; `out_valid` rises at T+33.
- Fast-path latency: `out_valid` rises at T+1.
- `result` and `out_valid` hold stable until the `out_ready` cycle. `result` is never changed while `out_valid` is high.
- No same-cycle turnaround: `in_ready` is low in DONE. The earliest next accept is the cycle after the `out_ready` handshake, so there is one bubble per operation.
- Handshake inputs (`in_valid`, `out_ready`) are ignored in states where they have no meaning. Operands may change freely after accept.
- rst or kill mid-CALC: the next cycle is IDLE with `in_ready`=1 (rst: once rst is released). No stale `out_valid` ever appears.
- The counter wraps never: exactly 32 CALC cycles per operation. The remainder register is 33 bits wide so the compare cannot overflow.

## Test plan
- DIVU 100/7, accept at T with `out_ready`=1: `out_valid` at T+33 only, `result`=14; REMU of the same operands gives 2.
- Signed operations:
  - DIV -7/2 gives 32'hFFFFFFFD (-3); REM -7/2 gives 32'hFFFFFFFF (-1).
  - DIV 7/-2 gives -3; REM 7/-2 gives 1.
- Special cases, each with `out_valid` at T+1:
  - DIV 5/0 gives 32'hFFFFFFFF; REMU 5/0 gives 5.
  - DIV 32'h80000000 / 32'hFFFFFFFF gives 32'h80000000; REM of the same gives 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`; `result` stays stable and `in_ready` stays 0. Release: `out_valid` drops the next cycle, and a new accept is possible then.
- kill at T+10 of a DIVU: `busy`=0 and `in_ready`=1 at T+11, and no `out_valid` occurs. Then a new DIVU 9/3 accepted at T+11 returns 3 at T+44.
- Reset: assert rst during CALC; the next cycle has state IDLE, `out_valid`=0, `result`=0, and `in_ready` stays 0 until rst deasserts. Also check `in_valid` together with kill in IDLE: no accept occurs.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready
// handshakes on both sides, RV32M special-case handling and a registered result.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  operator,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    // Operator codes shared with the ALU decode.
    localparam logic [4:0] ALU_OPERATOR_DIV  = 5'd20;
    localparam logic [4:0] ALU_OPERATOR_DIVU = 5'd21;
    localparam logic [4:0] ALU_OPERATOR_REM  = 5'd22;
    localparam logic [4:0] ALU_OPERATOR_REMU = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quo_q, quo_d;
    logic        sel_rem_q, sel_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        signed_q, signed_d;
    logic [31:0] result_q, result_d;
    logic        out_valid_q, out_valid_d;

    logic        accept_s;
    logic        op_valid_s;
    logic        op_signed_s;
    logic        op_rem_s;
    logic        s1_s;
    logic        s2_s;
    logic [31:0] abs1_s;
    logic [31:0] abs2_s;
    logic        div_zero_s;
    logic        overflow_s;
    logic [32:0] rem_shift_s;
    logic [32:0] rem_sub_s;
    logic        sub_ok_s;
    logic [32:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] quo_final_s;
    logic [31:0] rem_final_s;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    assign accept_s = in_valid && in_ready && !kill;

    // Decode the operator into kind flags.
    always_comb begin
        op_valid_s  = 1'b1;
        op_signed_s = 1'b0;
        op_rem_s    = 1'b0;
        case (operator)
            ALU_OPERATOR_DIV:  op_signed_s = 1'b1;
            ALU_OPERATOR_DIVU: op_signed_s = 1'b0;
            ALU_OPERATOR_REM: begin
                op_signed_s = 1'b1;
                op_rem_s    = 1'b1;
            end
            ALU_OPERATOR_REMU: op_rem_s = 1'b1;
            default:           op_valid_s = 1'b0;
        endcase
    end

    assign s1_s       = op_signed_s && operand1[31];
    assign s2_s       = op_signed_s && operand2[31];
    assign abs1_s     = s1_s ? neg32(operand1) : operand1;
    assign abs2_s     = s2_s ? neg32(operand2) : operand2;
    assign div_zero_s = (operand2 == 32'h0000_0000);
    assign overflow_s = op_signed_s && (operand1 == 32'h8000_0000) &&
                        (operand2 == 32'hFFFF_FFFF);

    // One restoring step; the 33-bit remainder keeps the compare overflow-free.
    assign rem_shift_s = {rem_q[31:0], dvd_q[31]};
    assign rem_sub_s   = rem_shift_s - {1'b0, dvs_q};
    assign sub_ok_s    = (rem_shift_s >= {1'b0, dvs_q});
    assign rem_step_s  = sub_ok_s ? rem_sub_s : rem_shift_s;
    assign quo_step_s  = {quo_q[30:0], sub_ok_s};
    assign quo_final_s = neg_quo_q ? neg32(quo_step_s) : quo_step_s;
    assign rem_final_s = neg_rem_q ? neg32(rem_step_s[31:0]) : rem_step_s[31:0];

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        sel_rem_d   = sel_rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        signed_d    = signed_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    signed_d  = op_signed_s;
                    sel_rem_d = op_rem_s;
                    neg_quo_d = s1_s ^ s2_s;
                    neg_rem_d = s1_s;
                    dvd_d     = abs1_s;
                    dvs_d     = abs2_s;
                    quo_d     = 32'h0000_0000;
                    rem_d     = 33'h0_0000_0000;
                    cnt_d     = 5'd31;
                    if (div_zero_s) begin
                        result_d    = op_rem_s ? operand1 : 32'hFFFF_FFFF;
                        out_valid_d = 1'b1;
                        cnt_d       = 5'd0;
                        state_d     = DONE;
                    end else if (overflow_s) begin
                        result_d    = op_rem_s ? 32'h0000_0000 : 32'h8000_0000;
                        out_valid_d = 1'b1;
                        cnt_d       = 5'd0;
                        state_d     = DONE;
                    end else if (!op_valid_s) begin
                        result_d    = 32'h0000_0000;
                        out_valid_d = 1'b1;
                        cnt_d       = 5'd0;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                dvd_d = {dvd_q[30:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    result_d    = sel_rem_q ? rem_final_s : quo_final_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Flush wins over accept, iteration and the output handshake.
        if (kill) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = 5'd0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            rem_q       <= 33'h0_0000_0000;
            dvd_q       <= 32'h0000_0000;
            dvs_q       <= 32'h0000_0000;
            quo_q       <= 32'h0000_0000;
            sel_rem_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            signed_q    <= 1'b0;
            result_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            sel_rem_q   <= sel_rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            signed_q    <= signed_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: arithmetic, special cases, latency,
// backpressure, kill and reset behaviour against hand-computed values.
module tb_div_sequencer;

    localparam logic [4:0] OP_DIV  = 5'd20;
    localparam logic [4:0] OP_DIVU = 5'd21;
    localparam logic [4:0] OP_REM  = 5'd22;
    localparam logic [4:0] OP_REMU = 5'd23;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  operator;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operator  (operator),
        .operand1  (operand1),
        .operand2  (operand2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for out_valid; returns in DONE when rdy=0.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input logic rdy);
        int lat;
        operator  = op;
        operand1  = a;
        operand2  = b;
        in_valid  = 1'b1;
        out_ready = rdy;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, exp);
        if (rdy) begin
            step();
            chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
            chk({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
        end else begin
            chk({tag, "_busy_held"}, {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        operator  = 5'd0;
        operand1  = 32'd0;
        operand2  = 32'd0;
        kill      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b1);
        do_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b1);
        do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33, 1'b1);

        // Backpressure: result and in_ready frozen while out_ready is low.
        do_op("bp_divu", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            step();
            chk("bp_result_stable", result, 32'd100);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ov", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        do_op("bp_next_divu", OP_DIVU, 32'd81, 32'd9, 32'd9, 33, 1'b1);

        // Kill at T+10 of a DIVU, then a new op at T+11 completing at T+44.
        operator = OP_DIVU;
        operand1 = 32'd50;
        operand2 = 32'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("kill_no_early_ov", {31'd0, out_valid}, 32'd0);
            step();
        end
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
        chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
        do_op("after_kill_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);

        // Reset during CALC.
        operator = OP_DIVU;
        operand1 = 32'd77;
        operand2 = 32'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("rstcalc_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstcalc_result", result, 32'd0);
        chk("rstcalc_busy", {31'd0, busy}, 32'd0);
        chk("rstcalc_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("rstcalc_in_ready_hold", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rstcalc_released_ready", {31'd0, in_ready}, 32'd1);

        // in_valid together with kill in IDLE must not accept.
        operator = OP_DIVU;
        operand1 = 32'd10;
        operand2 = 32'd2;
        in_valid = 1'b1;
        kill     = 1'b1;
        step();
        in_valid = 1'b0;
        kill     = 1'b0;
        chk("killacc_busy", {31'd0, busy}, 32'd0);
        chk("killacc_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("killacc_out_valid", {31'd0, out_valid}, 32'd0);
        chk("killacc_busy2", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
